fx_ctrl_regs: RTL and testbench

- Parametrised control/status register bank on the FX bus, replacing the constant-readback control stub.
- Decodes an FX address window at BASE and holds NREG writable control registers, plus read-only ID and status locations.
- Returns read data with fixed 1-cycle latency and a valid strobe.
- Drives control outputs and per-register write strobes into the rest of the FPGA.

---
 rtl/fx_ctrl_regs.sv | 106 ++++++++++
 tb/tb_fx_ctrl_regs.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fx_ctrl_regs.sv
// FX-bus control/status register bank: ID, STAT, NREG read/write CTRL registers, 1-cycle read latency.
// Optional FX_WRCNT_EN adds a read-only CTRL-write counter at offset NREG+2.
module fx_ctrl_regs #(
  parameter int              DW        = 8,
  parameter int              AW        = 22,
  parameter logic [AW-1:0]   BASE      = '0,
  parameter int              NREG      = 8,
  parameter logic [DW-1:0]   ID_VAL    = 'h5a,
  parameter logic [DW-1:0]   DEFAULT_Q = 'h5a,
  parameter logic [NREG-1:0] CLR_MASK  = '0
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic               fx_wr,
  input  logic [AW-1:0]      fx_waddr,
  input  logic [DW-1:0]      fx_data,
  input  logic               fx_rd,
  input  logic [AW-1:0]      fx_raddr,
  output logic [DW-1:0]      fx_q,
  output logic               fx_q_vld,
  input  logic [DW-1:0]      stat_in,
  output logic [NREG*DW-1:0] ctrl_q,
  output logic [NREG-1:0]    ctrl_wstb
);

  // Offsets carry a borrow bit so "below BASE" is detected even when the window wraps past 2^AW.
  logic          w_wborrow, w_rborrow;
  logic [AW-1:0] w_woff, w_roff;
  logic [NREG-1:0] w_wr_hit;
  logic [DW-1:0] w_rdata;

  logic [DW-1:0]   r_ctrl [NREG];
  logic [NREG-1:0] r_wstb;
  logic [DW-1:0]   r_q;
  logic            r_q_vld;

  assign {w_wborrow, w_woff} = {1'b0, fx_waddr} - {1'b0, BASE};
  assign {w_rborrow, w_roff} = {1'b0, fx_raddr} - {1'b0, BASE};

  genvar k;
  generate
    for (k = 0; k < NREG; k++) begin : g_ctrl
      assign w_wr_hit[k] = fx_wr && !w_wborrow && (w_woff == AW'(k + 2));
      assign ctrl_q[k*DW +: DW] = r_ctrl[k];

      // A write always wins over the self-clear of a pulse register.
      always_ff @(posedge clk_sys) begin
        if (rst) begin
          r_ctrl[k] <= '0;
          r_wstb[k] <= 1'b0;
        end else begin
          r_wstb[k] <= w_wr_hit[k];
          if (w_wr_hit[k])
            r_ctrl[k] <= fx_data;
          else if (CLR_MASK[k])
            r_ctrl[k] <= '0;
        end
      end
    end
  endgenerate

`ifdef FX_WRCNT_EN
  logic [DW-1:0] r_wrcnt;

  always_ff @(posedge clk_sys) begin
    if (rst)
      r_wrcnt <= '0;
    else if (|w_wr_hit)
      r_wrcnt <= r_wrcnt + DW'(1);
  end
`endif

  // Read mux sees pre-edge state, so same-cycle writes/increments are not visible yet.
  always_comb begin
    w_rdata = DEFAULT_Q;
    if (!w_rborrow) begin
      if (w_roff == AW'(0))
        w_rdata = ID_VAL;
      else if (w_roff == AW'(1))
        w_rdata = stat_in;
      for (int i = 0; i < NREG; i++)
        if (w_roff == AW'(i + 2))
          w_rdata = r_ctrl[i];
`ifdef FX_WRCNT_EN
      if (w_roff == AW'(NREG + 2))
        w_rdata = r_wrcnt;
`endif
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_q     <= '0;
      r_q_vld <= 1'b0;
    end else begin
      r_q_vld <= fx_rd;
      if (fx_rd)
        r_q <= w_rdata;
    end
  end

  assign fx_q      = r_q;
  assign fx_q_vld  = r_q_vld;
  assign ctrl_wstb = r_wstb;

endmodule

// File: tb/tb_fx_ctrl_regs.sv
// Bench for fx_ctrl_regs: two instances (low BASE and a BASE whose window wraps past 2^AW)
// checked every cycle against an array-based register-map model; honours FX_WRCNT_EN.
module tb_fx_ctrl_regs;
  localparam int DW = 8;
  localparam int AW = 22;
  localparam int NREG = 8;
  localparam logic [21:0] B0 = 22'h000100;
  localparam logic [21:0] B1 = 22'h3ffffc;
  localparam logic [7:0] IDV = 8'h5a;
  localparam logic [7:0] DEFQ = 8'h5a;
  localparam logic [7:0] CLR = 8'h02;
`ifdef FX_WRCNT_EN
  localparam bit HAS_CNT = 1'b1;
`else
  localparam bit HAS_CNT = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic rst, fx_wr, fx_rd;
  logic [21:0] fx_waddr, fx_raddr;
  logic [7:0] fx_data, stat_in;
  logic [7:0] q0, q1;
  logic vld0, vld1;
  logic [63:0] cq0, cq1;
  logic [7:0] ws0, ws1;

  always #5 clk_sys = ~clk_sys;

  fx_ctrl_regs #(.DW(DW), .AW(AW), .BASE(B0), .NREG(NREG), .ID_VAL(IDV),
                 .DEFAULT_Q(DEFQ), .CLR_MASK(CLR)) u_lo (
    .clk_sys(clk_sys), .rst(rst), .fx_wr(fx_wr), .fx_waddr(fx_waddr), .fx_data(fx_data),
    .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(q0), .fx_q_vld(vld0), .stat_in(stat_in),
    .ctrl_q(cq0), .ctrl_wstb(ws0));

  fx_ctrl_regs #(.DW(DW), .AW(AW), .BASE(B1), .NREG(NREG), .ID_VAL(IDV),
                 .DEFAULT_Q(DEFQ), .CLR_MASK(CLR)) u_hi (
    .clk_sys(clk_sys), .rst(rst), .fx_wr(fx_wr), .fx_waddr(fx_waddr), .fx_data(fx_data),
    .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(q1), .fx_q_vld(vld1), .stat_in(stat_in),
    .ctrl_q(cq1), .ctrl_wstb(ws1));

  // Reference model: register contents per instance, indexed by register number.
  logic [21:0] bases [2];
  logic [7:0] m_ctrl [2][NREG];
  logic [7:0] m_wstb [2];
  logic [7:0] m_q [2];
  logic       m_vld [2];
  logic [7:0] m_cnt [2];
  int n_assert = 0;
  int n_fail = 0;

  function automatic logic [21:0] ad(int d, int off);
    return bases[d] + 22'(off);
  endfunction

  function automatic logic [7:0] mread(int d, logic [21:0] a);
    int off;
    if (a < bases[d]) return DEFQ;
    off = int'(a - bases[d]);
    if (off == 0) return IDV;
    if (off == 1) return stat_in;
    if (off < NREG + 2) return m_ctrl[d][off-2];
    if (HAS_CNT && off == NREG + 2) return m_cnt[d];
    return DEFQ;
  endfunction

  function automatic int widx(int d, logic [21:0] a);
    int off;
    if (a < bases[d]) return -1;
    off = int'(a - bases[d]);
    if (off >= 2 && off < NREG + 2) return off - 2;
    return -1;
  endfunction

  function automatic logic [63:0] flat(int d);
    logic [63:0] f;
    for (int k = 0; k < NREG; k++) f[k*8 +: 8] = m_ctrl[d][k];
    return f;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic r, logic w, logic [21:0] wa, logic [7:0] wd, logic rd, logic [21:0] ra);
    rst = r; fx_wr = w; fx_waddr = wa; fx_data = wd; fx_rd = rd; fx_raddr = ra;
  endtask

  // Advance the model by one edge using the current inputs, clock the DUTs, compare everything.
  task automatic cycle();
    int k;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < NREG; i++) m_ctrl[d][i] = 8'h00;
        m_wstb[d] = 8'h00; m_q[d] = 8'h00; m_vld[d] = 1'b0; m_cnt[d] = 8'h00;
      end else begin
        m_vld[d] = fx_rd;
        if (fx_rd) m_q[d] = mread(d, fx_raddr);
        m_wstb[d] = 8'h00;
        for (int i = 0; i < NREG; i++) if (CLR[i]) m_ctrl[d][i] = 8'h00;
        k = widx(d, fx_waddr);
        if (fx_wr && k >= 0) begin
          m_ctrl[d][k] = fx_data;
          m_wstb[d][k] = 1'b1;
          m_cnt[d] = m_cnt[d] + 8'd1;
        end
      end
    end
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("lo_q", 64'(q0), 64'(m_q[0]));
    chk("lo_vld", 64'(vld0), 64'(m_vld[0]));
    chk("lo_ctrl", cq0, flat(0));
    chk("lo_wstb", 64'(ws0), 64'(m_wstb[0]));
    chk("hi_q", 64'(q1), 64'(m_q[1]));
    chk("hi_vld", 64'(vld1), 64'(m_vld[1]));
    chk("hi_ctrl", cq1, flat(1));
    chk("hi_wstb", 64'(ws1), 64'(m_wstb[1]));
  endtask

  initial begin
    bases[0] = B0; bases[1] = B1;
    stat_in = 8'h3c;
    drive(1, 0, '0, '0, 0, '0);
    cycle(); cycle();
    chk("rst_q", 64'(q0), 64'h00);
    chk("rst_ctrl", cq0, 64'h0);

    // ID, STAT, out-of-window, and every CTRL after reset
    drive(0, 0, '0, '0, 1, ad(0, 0)); cycle(); chk("id_rd", 64'(q0), 64'h5a);
    drive(0, 0, '0, '0, 1, ad(0, 1)); cycle(); chk("stat_rd", 64'(q0), 64'h3c);
    drive(0, 0, '0, '0, 1, ad(0, NREG + 5)); cycle(); chk("oob_rd", 64'(q0), 64'h5a);
    for (int i = 0; i < NREG; i++) begin
      drive(0, 0, '0, '0, 1, ad(0, i + 2)); cycle();
    end
    drive(0, 0, '0, '0, 1, 22'h0000ff); cycle(); chk("below_base", 64'(q0), 64'h5a);
    drive(0, 0, '0, '0, 0, '0); cycle(); chk("vld_idle", 64'(vld0), 64'h0);

    // wrapped window on the high instance: address 0 is below BASE
    drive(0, 0, '0, '0, 1, ad(1, 0)); cycle(); chk("hi_id", 64'(q1), 64'h5a);
    drive(0, 0, '0, '0, 1, 22'h000000); cycle(); chk("hi_wrap_oob", 64'(q1), 64'h5a);
    drive(0, 1, ad(1, 3), 8'h66, 0, '0); cycle(); chk("hi_top_wr", cq1[15:8], 64'h66);

    // plain write and readback
    drive(0, 1, ad(0, 2), 8'ha5, 0, '0); cycle(); chk("wstb0", 64'(ws0), 64'h01);
    drive(0, 0, '0, '0, 1, ad(0, 2)); cycle(); chk("rd_a5", 64'(q0), 64'ha5);
    chk("wstb0_off", 64'(ws0), 64'h00);

    // self-clearing CTRL[1]
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, ad(0, 3), 8'hff, 0, '0); cycle(); chk("pulse_hold", cq0[15:8], 64'hff);
    end
    drive(0, 0, '0, '0, 0, '0); cycle(); chk("pulse_clr", cq0[15:8], 64'h00);
    cycle();

    // read-before-write on CTRL[2]
    drive(0, 1, ad(0, 4), 8'h77, 0, '0); cycle();
    drive(0, 1, ad(0, 4), 8'h11, 1, ad(0, 4)); cycle(); chk("rbw_old", 64'(q0), 64'h77);
    drive(0, 0, '0, '0, 1, ad(0, 4)); cycle(); chk("rbw_new", 64'(q0), 64'h11);
    drive(0, 1, ad(0, 0), 8'h00, 0, '0); cycle(); chk("id_wr_nostb", 64'(ws0), 64'h00);
    drive(0, 1, ad(0, 1), 8'h00, 1, ad(0, 0)); cycle(); chk("id_kept", 64'(q0), 64'h5a);

    // reset in the middle of a write burst
    for (int i = 0; i < 16; i++) begin
      drive(i == 5, 1, ad(0, 2 + (i % NREG)), 8'(8'h30 + i), 0, '0); cycle();
      if (i == 5) chk("burst_rst", cq0, 64'h0);
    end

    // offset NREG+2: counter when enabled, otherwise out of window
    drive(1, 0, '0, '0, 0, '0); cycle();
    for (int i = 0; i < 257; i++) begin
      drive(0, 1, ad(0, 2 + (i % NREG)), 8'(i), 0, '0); cycle();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, ad(0, 0), 8'h01, 0, '0); cycle();
    end
    drive(0, 0, '0, '0, 1, ad(0, NREG + 2)); cycle();
    chk("wrcnt", 64'(q0), HAS_CNT ? 64'h01 : 64'h5a);

    // randomized traffic around both windows
    for (int n = 0; n < 600; n++) begin
      stat_in = 8'($urandom);
      drive($urandom_range(0, 59) == 0, 1'($urandom),
            ad($urandom_range(0, 1), $urandom_range(0, NREG + 7) - 3), 8'($urandom),
            1'($urandom), ad($urandom_range(0, 1), $urandom_range(0, NREG + 7) - 3));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
